// File: rtl/ysyx_22040365_ex_muldiv.sv
// Iterative radix-2 RV64M multiply/divide unit, XLEN+1 cycle latency, valid/ready in and out.
// Define YSYX_22040365_MULDIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow at accept.
module ysyx_22040365_ex_muldiv #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ex_result,
  output logic [4:0]      rd_out,
  output logic            wen_rd,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;
  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   a_q, a_d, res_q, res_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;

  logic              accept, early, is_div, sgn_a, sgn_b, neg_a, neg_b, op2_zero, neg_res;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     sum, trial;
  logic [2*XLEN-1:0] mul_next, div_next, step, mul_full;
  logic [XLEN-1:0]   final_res;

  assign accept = in_valid && (state_q == StIdle) && !flush;

  // Operand decode: magnitudes plus the sign to reapply at the end.
  always_comb begin
    is_div   = op[2];
    sgn_a    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    sgn_b    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    neg_a    = sgn_a && op1[XLEN-1];
    neg_b    = sgn_b && op2[XLEN-1];
    mag_a    = neg_a ? -op1 : op1;
    mag_b    = neg_b ? -op2 : op2;
    op2_zero = (op2 == '0);
    // Zero divisor yields an all-ones quotient only if it is never negated.
    neg_res  = is_div ? (op[1] ? neg_a : ((neg_a ^ neg_b) && !op2_zero)) : (neg_a ^ neg_b);
  end

`ifdef YSYX_22040365_MULDIV_EARLY_OUT_EN
  logic            ovf;
  logic [XLEN-1:0] special_res;
  always_comb begin
    ovf         = !op[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    special_res = op2_zero ? (op[1] ? op1 : '1) : (op[1] ? '0 : op1);
    early       = is_div && (op2_zero || ovf);
  end
`else
  assign early = 1'b0;
`endif

  // One iteration: shift/add for multiply, restoring shift/subtract for divide.
  always_comb begin
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {sum, acc_q[XLEN-1:1]};
    trial    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, a_q};
    div_next = trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                           : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step     = op_q[2] ? div_next : mul_next;
    mul_full = neg_q ? -step : step;
    case (op_q)
      3'b000:                 final_res = mul_full[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = mul_full[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
      default:                final_res = neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    a_d   = a_q;
    op_d  = op_q;
    rd_d  = rd_q;
    neg_d = neg_q;
    res_d = res_q;
    if (accept) begin
      op_d  = op;
      rd_d  = rd_in;
      neg_d = neg_res;
      a_d   = is_div ? mag_b : mag_a;
      acc_d = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
      cnt_d = CNT_W'(XLEN);
`ifdef YSYX_22040365_MULDIV_EARLY_OUT_EN
      if (early) begin
        res_d = special_res;
        cnt_d = '0;
      end
`endif
    end else if (state_q == StCalc && !flush) begin
      acc_d = step;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) res_d = final_res;
    end
    if (flush) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      a_q   <= '0;
      op_q  <= '0;
      rd_q  <= '0;
      neg_q <= 1'b0;
      res_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      a_q   <= a_d;
      op_q  <= op_d;
      rd_q  <= rd_d;
      neg_q <= neg_d;
      res_q <= res_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = early ? StDone : StCalc;
      StCalc:  if (cnt_q == CNT_W'(1)) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    ex_result = res_q;
    rd_out    = rd_q;
    wen_rd    = out_valid && (rd_q != 5'd0);
  end

endmodule

// File: tb/tb_ysyx_22040365_ex_muldiv.sv
// Directed self-checking bench for ysyx_22040365_ex_muldiv at XLEN=64.
// Expected special-case latency follows YSYX_22040365_MULDIV_EARLY_OUT_EN.
module tb_ysyx_22040365_ex_muldiv;

  localparam int LAT     = 65;
  localparam int LAT_MAX = 200;
`ifdef YSYX_22040365_MULDIV_EARLY_OUT_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = 65;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, wen_rd, busy;
  logic [2:0]  op;
  logic [63:0] op1, op2, ex_result;
  logic [4:0]  rd_in, rd_out;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_22040365_ex_muldiv #(.XLEN(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .rd_in     (rd_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ex_result (ex_result),
    .rd_out    (rd_out),
    .wen_rd    (wen_rd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    op1      = a;
    op2      = b;
    rd_in    = rd;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Latency counts edges from the accepting edge inclusive.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < LAT_MAX) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, " idle"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp,
                        input int exp_lat);
    int lat;
    issue(o, a, b, rd);
    wait_done(lat);
    check_eq({tag, " lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " res"}, ex_result, exp);
    check_eq({tag, " rd"}, {59'd0, rd_out}, {59'd0, rd});
    check_eq({tag, " wen"}, {63'd0, wen_rd}, {63'd0, (rd != 5'd0)});
    release_result(tag);
  endtask

  initial begin
    int   lat;
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = 3'd0; op1 = '0; op2 = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst busy", {63'd0, busy}, 64'd0);
    check_eq("rst out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst result", ex_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul", 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, LAT);
    run_op("mulhu", 3'b011, '1, '1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, LAT);
    run_op("mulh", 3'b001, '1, '1, 5'd2, 64'd0, LAT);
    run_op("mulhsu", 3'b010, '1, 64'd2, 5'd3, '1, LAT);
    run_op("div", 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFFD, LAT);
    run_op("rem", 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd0, '1, LAT);
    run_op("div neg", 3'b100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, LAT);
    run_op("rem neg", 3'b110, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd4, 64'd1, LAT);

    run_op("divu0", 3'b101, 64'd12345, 64'd0, 5'd6, '1, SP_LAT);
    run_op("div0", 3'b100, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd6, '1, SP_LAT);
    run_op("rem0", 3'b110, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFB, SP_LAT);
    run_op("divovf", 3'b100, 64'h8000_0000_0000_0000, '1, 5'd7, 64'h8000_0000_0000_0000, SP_LAT);
    run_op("removf", 3'b110, 64'h8000_0000_0000_0000, '1, 5'd7, 64'd0, SP_LAT);

    // Backpressure: result must hold while out_ready is low.
    issue(3'b101, 64'd100, 64'd7, 5'd3);
    wait_done(lat);
    check_eq("hold lat", 64'(lat), 64'(LAT));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold res", ex_result, 64'd14);
      check_eq("hold valid", {63'd0, out_valid}, 64'd1);
      check_eq("hold in_ready", {63'd0, in_ready}, 64'd0);
    end
    release_result("hold");
    run_op("b2b remu", 3'b111, 64'd100, 64'd7, 5'd3, 64'd2, LAT);

    // Flush in the middle of CALC.
    issue(3'b000, 64'd3, 64'd4, 5'd8);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_eq("flush busy", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq("flush no valid", {63'd0, seen}, 64'd0);

    // Flush beats an accept in IDLE.
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check_eq("flush accept busy", {63'd0, busy}, 64'd0);

    // Asynchronous reset mid-CALC.
    issue(3'b000, 64'd7, 64'd9, 5'd9);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst busy", {63'd0, busy}, 64'd0);
    check_eq("arst in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("arst out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("arst result", ex_result, 64'd0);
    check_eq("arst rd_out", {59'd0, rd_out}, 64'd0);
    check_eq("arst wen", {63'd0, wen_rd}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post rst mul", 3'b000, 64'd7, 64'd9, 5'd9, 64'd63, LAT);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
